hdmi_to_blocks: RTL
===================

# hdmi_to_blocks

Raster-to-block converter on the encoder input side of the JPEG path. It accepts an HDMI-style YCrCb pixel stream at N pixels per clock, buffers each 8-line band in a ping-pong line memory, and emits 8x8 blocks in raster-of-blocks order with sob/eob/sof framing. It performs the inverse function of blocks_to_hdmi, and its output stream uses the same framing that blocks_to_hdmi consumes.

## Interface
- N, 2, pixels per beat on both sides; legal values are 1, 2, 4, 8.
- X_RES, 2160, active pixels per line; must be a multiple of 8.
- Y_RES, 1200, active lines per frame; must be a multiple of 8.

- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, asynchronous, active-low.
- hdmi_v_sync  in  1  active-high; any high cycle starts a new frame.
- hdmi_h_sync  in  1  active-high line sync; informational only, ignored by the block.
- hdmi_data_valid  in  1  marks an active beat of N pixels.
- hdmi_data_y / hdmi_data_cr / hdmi_data_cb  in  N×8 signed each  pixel lanes; lane 0 is the leftmost pixel.
- blk_valid  out  1  output beat valid; there is no backpressure.
- blk_data_y / blk_data_cr / blk_data_cb  out  N×8 signed each  block beat.
- blk_sob  out  1  first beat of a block.
- blk_eob  out  1  last beat of a block.
- blk_sof  out  1  first beat of the first block of a frame; coincides with blk_sob.
- err  out  1  sticky error flag; cleared only by reset.

## Operation
- Storage: per component, 2 banks × 8 lines × X_RES/N words of N×8 bits. Memory read is synchronous with 1-cycle latency.
- Write side counters:
  - wcol counts 0..X_RES/N-1.
  - wline counts 0..7.
  - wband counts 0..Y_RES/8-1.
  - wbank is 0 or 1.
- Each valid beat is written to word wbank·8·X_RES/N + wline·X_RES/N + wcol.
  - wcol wraps to 0 and increments wline.
  - When wline wraps, the band is complete: wbank toggles, wband increments, and a read of the finished bank is launched.
- Frame boundaries:
  - hdmi_v_sync high clears wcol, wline, wband and sets sof_pending.
  - The first band launched after that sets blk_sof on its first beat, then clears sof_pending.
  - After Y_RES/8 bands the write side is in DONE. It ignores valid beats and sets err on each one until the next v_sync.
- v_sync arriving while wcol≠0 or wline≠0:
  - The partial band is discarded (same wbank is reused) and err is set.
  - A read already in progress completes unaffected.
- Read FSM has two states, IDLE and READ, with counters:
  - blk counts 0..X_RES/8-1.
  - row counts 0..7.
  - k counts 0..8/N-1.
- Read address is rbank·8·X_RES/N + row·X_RES/N + blk·8/N + k. Order is k innermost, then row, then blk.
- Beat index is i = row·(8/N)+k.
  - blk_sob is asserted at i=0.
  - blk_eob is asserted at i=64/N-1.
- READ→IDLE after the eob beat of the last block.
- A band completing while the read FSM is in READ:
  - The read is not restarted.
  - err is set.
  - The new band is queued, depth 1, and starts immediately after the current read finishes.
  - Further overflow is dropped.
- Pixel data passes through unmodified; the block does no arithmetic on it.

## Timing
- Reset values:
  - blk_valid, blk_sob, blk_eob, blk_sof, err = 0.
  - blk_data_* = 0.
  - All counters = 0, wbank = 0, FSM in IDLE, sof_pending = 0.
- Latency: the last write beat of a band at cycle T gives the first blk_valid at T+2.
- Blocks are back-to-back: one beat per cycle, 64/N cycles per block, X_RES·8/N cycles per band, with no gaps inside a band.
- With legal HDMI timing, where a line is X_RES/N plus blanking cycles, a band read always finishes before the next band completes, so err never fires.
- Asynchronous reset mid-frame clears everything immediately. Outputs drop to 0 in the same cycle, and partial data is lost.
- v_sync and data_valid in the same cycle: v_sync takes effect first, and that beat is written as beat 0 of line 0.
- Memory contents are not reset.

## Test plan
- Basic ordering, with N=2, X_RES=16, Y_RES=16 and pixel(l,c): Y=l·16+c, Cr=Y+1, Cb=Y+2, 2 blanking cycles per line, one frame.
  - Required output: 4 blocks × 32 beats.
  - Block 0, beat 0: Y lanes {0,1}, sob=sof=1.
  - Block 0, beat 4: {16,17}.
  - Block 0, beat 31: {118,119}, eob=1.
  - Block 1, beat 0: {8,9}, sof=0.
- Second band: block 2, beat 0 has Y={-128,-127} (128/129 interpreted as signed). Its first blk_valid occurs exactly 2 cycles after line 15's last beat.
- Two consecutive frames: blk_sof fires exactly twice, on the first beat of each frame's block 0, and err stays 0.
- Mid-band v_sync after 3 lines:
  - err goes to 1.
  - The next full frame outputs correct data starting from line 0.
  - No block is emitted for the partial band.
- Overflow, with 0 blanking cycles and a stalled schedule that forces a band to complete while in READ: err=1, and the queued band is emitted immediately after the prior eob.
- Reset mid-READ: all outputs are 0 in the reset cycle. After release, a new frame behaves exactly as in the basic ordering scenario.

Source files
------------

// File: rtl/hdmi_to_blocks.sv
// Raster-to-block converter: buffers 8-line bands of an N-pixel/clock YCrCb stream in a
// ping-pong line memory and replays them as 8x8 blocks with sob/eob/sof framing.
module hdmi_to_blocks #(
   parameter int unsigned N     = 2,
   parameter int unsigned X_RES = 2160,
   parameter int unsigned Y_RES = 1200
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                hdmi_v_sync,
   input  logic                hdmi_h_sync,
   input  logic                hdmi_data_valid,
   input  logic signed [N*8-1:0] hdmi_data_y,
   input  logic signed [N*8-1:0] hdmi_data_cr,
   input  logic signed [N*8-1:0] hdmi_data_cb,
   output logic                blk_valid,
   output logic signed [N*8-1:0] blk_data_y,
   output logic signed [N*8-1:0] blk_data_cr,
   output logic signed [N*8-1:0] blk_data_cb,
   output logic                blk_sob,
   output logic                blk_eob,
   output logic                blk_sof,
   output logic                err
);
   localparam int unsigned W     = N * 8;
   localparam int unsigned WPL   = X_RES / N;
   localparam int unsigned BPB   = 8 / N;
   localparam int unsigned NBLK  = X_RES / 8;
   localparam int unsigned NBAND = Y_RES / 8;
   localparam int unsigned DEPTH = 16 * WPL;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CW    = (WPL > 1) ? $clog2(WPL) : 1;
   localparam int unsigned BW    = (NBAND > 1) ? $clog2(NBAND) : 1;
   localparam int unsigned LW    = (NBLK > 1) ? $clog2(NBLK) : 1;
   localparam int unsigned KW    = (BPB > 1) ? $clog2(BPB) : 1;

   typedef enum logic [0:0] {StIdle, StRead} state_e;

   logic [3*W-1:0] r_mem [DEPTH];

   logic [CW-1:0] r_wcol;
   logic [2:0]    r_wline;
   logic [BW-1:0] r_wband;
   logic          r_wbank, r_wdone, r_sof_pending;

   state_e        r_state, w_state_nxt;
   logic [LW-1:0] r_blk, w_blk_nxt;
   logic [2:0]    r_row, w_row_nxt;
   logic [KW-1:0] r_k, w_k_nxt;
   logic          r_rbank, w_rbank_nxt, r_rsof, w_rsof_nxt;
   logic          r_q_valid, w_q_valid_nxt, r_q_bank, w_q_bank_nxt, r_q_sof, w_q_sof_nxt;
   logic          r_valid, r_sob, r_eob, r_sof, r_err;
   logic [3*W-1:0] r_rdata;

   logic [CW-1:0] w_col_eff;
   logic [2:0]    w_line_eff;
   logic [BW-1:0] w_band_eff;
   logic          w_done_eff, w_sofp_eff, w_we, w_col_last, w_line_last, w_launch;
   logic          w_rd, w_beat_last, w_band_done, w_ovf_err, w_err_vs, w_err_done;
   logic [AW-1:0] w_waddr, w_raddr;
   logic          w_unused;

   assign w_unused = hdmi_h_sync;

   // v_sync acts before a coincident valid beat, so the beat lands at line 0, column 0.
   assign w_col_eff   = hdmi_v_sync ? '0 : r_wcol;
   assign w_line_eff  = hdmi_v_sync ? '0 : r_wline;
   assign w_band_eff  = hdmi_v_sync ? '0 : r_wband;
   assign w_done_eff  = hdmi_v_sync ? 1'b0 : r_wdone;
   assign w_sofp_eff  = hdmi_v_sync | r_sof_pending;
   assign w_we        = hdmi_data_valid & ~w_done_eff;
   assign w_col_last  = (w_col_eff == CW'(WPL - 1));
   assign w_line_last = (w_line_eff == 3'd7);
   assign w_launch    = w_we & w_col_last & w_line_last;
   assign w_err_vs    = hdmi_v_sync & ((r_wcol != '0) | (r_wline != '0));
   assign w_err_done  = hdmi_data_valid & w_done_eff;

   assign w_waddr = AW'(32'(r_wbank) * 8 * WPL + 32'(w_line_eff) * WPL + 32'(w_col_eff));
   assign w_raddr = AW'(32'(r_rbank) * 8 * WPL + 32'(r_row) * WPL + 32'(r_blk) * BPB
                        + 32'(r_k));

   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= {hdmi_data_cb, hdmi_data_cr, hdmi_data_y};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wcol        <= '0;
         r_wline       <= '0;
         r_wband       <= '0;
         r_wbank       <= 1'b0;
         r_wdone       <= 1'b0;
         r_sof_pending <= 1'b0;
      end else begin
         r_wcol        <= w_col_eff;
         r_wline       <= w_line_eff;
         r_wband       <= w_band_eff;
         r_wdone       <= w_done_eff;
         r_sof_pending <= w_sofp_eff;
         if (w_we) begin
            if (!w_col_last) begin
               r_wcol <= w_col_eff + 1'b1;
            end else begin
               r_wcol <= '0;
               if (!w_line_last) begin
                  r_wline <= w_line_eff + 1'b1;
               end else begin
                  r_wline       <= '0;
                  r_wbank       <= ~r_wbank;
                  r_sof_pending <= 1'b0;
                  if (w_band_eff == BW'(NBAND - 1)) begin
                     r_wband <= '0;
                     r_wdone <= 1'b1;
                  end else begin
                     r_wband <= w_band_eff + 1'b1;
                  end
               end
            end
         end
      end
   end

   assign w_beat_last = (r_k == KW'(BPB - 1)) && (r_row == 3'd7);
   assign w_band_done = w_beat_last && (r_blk == LW'(NBLK - 1));

   always_comb begin
      w_state_nxt   = r_state;
      w_blk_nxt     = r_blk;
      w_row_nxt     = r_row;
      w_k_nxt       = r_k;
      w_rbank_nxt   = r_rbank;
      w_rsof_nxt    = r_rsof;
      w_q_valid_nxt = r_q_valid;
      w_q_bank_nxt  = r_q_bank;
      w_q_sof_nxt   = r_q_sof;
      w_rd          = 1'b0;
      w_ovf_err     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_launch) begin
               w_state_nxt = StRead;
               w_blk_nxt   = '0;
               w_row_nxt   = '0;
               w_k_nxt     = '0;
               w_rbank_nxt = r_wbank;
               w_rsof_nxt  = w_sofp_eff;
            end
         end
         StRead: begin
            w_rd      = 1'b1;
            w_ovf_err = w_launch;
            if (r_k != KW'(BPB - 1)) begin
               w_k_nxt = r_k + 1'b1;
            end else begin
               w_k_nxt = '0;
               if (r_row != 3'd7) begin
                  w_row_nxt = r_row + 1'b1;
               end else begin
                  w_row_nxt = '0;
                  w_blk_nxt = w_band_done ? '0 : r_blk + 1'b1;
               end
            end
            if (w_band_done) begin
               if (r_q_valid) begin
                  w_rbank_nxt   = r_q_bank;
                  w_rsof_nxt    = r_q_sof;
                  w_q_valid_nxt = w_launch;
                  w_q_bank_nxt  = r_wbank;
                  w_q_sof_nxt   = w_sofp_eff;
               end else if (w_launch) begin
                  w_rbank_nxt = r_wbank;
                  w_rsof_nxt  = w_sofp_eff;
               end else begin
                  w_state_nxt = StIdle;
               end
            end else if (w_launch && !r_q_valid) begin
               w_q_valid_nxt = 1'b1;
               w_q_bank_nxt  = r_wbank;
               w_q_sof_nxt   = w_sofp_eff;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_blk     <= '0;
         r_row     <= '0;
         r_k       <= '0;
         r_rbank   <= 1'b0;
         r_rsof    <= 1'b0;
         r_q_valid <= 1'b0;
         r_q_bank  <= 1'b0;
         r_q_sof   <= 1'b0;
         r_valid   <= 1'b0;
         r_sob     <= 1'b0;
         r_eob     <= 1'b0;
         r_sof     <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_blk     <= w_blk_nxt;
         r_row     <= w_row_nxt;
         r_k       <= w_k_nxt;
         r_rbank   <= w_rbank_nxt;
         r_rsof    <= w_rsof_nxt;
         r_q_valid <= w_q_valid_nxt;
         r_q_bank  <= w_q_bank_nxt;
         r_q_sof   <= w_q_sof_nxt;
         r_valid   <= w_rd;
         r_sob     <= w_rd && (r_row == '0) && (r_k == '0);
         r_eob     <= w_rd && w_beat_last;
         r_sof     <= w_rd && r_rsof && (r_row == '0) && (r_k == '0) && (r_blk == '0);
         r_err     <= r_err | w_err_vs | w_err_done | w_ovf_err;
         if (w_rd) r_rdata <= r_mem[w_raddr];
      end
   end

   assign blk_valid   = r_valid;
   assign blk_sob     = r_sob;
   assign blk_eob     = r_eob;
   assign blk_sof     = r_sof;
   assign err         = r_err;
   assign blk_data_y  = r_rdata[W-1:0];
   assign blk_data_cr = r_rdata[2*W-1:W];
   assign blk_data_cb = r_rdata[3*W-1:2*W];

endmodule
